// File: rtl/crc_stream_if.sv
// rtl/crc_stream_if.sv - word stream and result bundle for crc_stream
//
// Groups the word handshake (i_valid/o_ready), the frame data and controls,
// and the result outputs (o_valid/o_crc/o_busy) of crc_stream.
// Modports:
//   master - producer/consumer side: drives the i_* members, reads the o_* members
//   slave  - crc_stream side: reads the i_* members, drives the o_* members
// Optional member i_xorout exists only when CRC_STREAM_XOROUT_EN is defined.
interface crc_stream_if #(
    parameter int WDATA = 5,
    parameter int WPOLY = 4
);
    logic             i_valid;
    logic             o_ready;
    logic [WDATA-1:0] i_data;
    logic             i_first;
    logic             i_last;
    logic [WPOLY-1:0] i_poly;
    logic [WPOLY-2:0] i_crc;
`ifdef CRC_STREAM_XOROUT_EN
    logic [WPOLY-2:0] i_xorout;
`endif
    logic             o_valid;
    logic [WPOLY-2:0] o_crc;
    logic             o_busy;

    modport slave (
        input  i_valid, i_data, i_first, i_last, i_poly, i_crc,
`ifdef CRC_STREAM_XOROUT_EN
        input  i_xorout,
`endif
        output o_ready, o_valid, o_crc, o_busy
    );

    modport master (
        output i_valid, i_data, i_first, i_last, i_poly, i_crc,
`ifdef CRC_STREAM_XOROUT_EN
        output i_xorout,
`endif
        input  o_ready, o_valid, o_crc, o_busy
    );
endinterface

// File: rtl/crc_stream.sv
// rtl/crc_stream.sv - bit-serial CRC over a framed word stream
//
// Accepts WDATA-bit words and shifts them MSB first through a CRC register of
// width WPOLY-1, one bit per clock. A frame opens on a word with i_first (or
// any word when no frame is open), which loads the seed and the generator.
// When the last word of a frame finishes, the result is registered on o_crc
// and o_valid pulses for one cycle.
// Ports:
//   i_clk       - clock, rising edge
//   i_rst       - synchronous active-high reset
//   bus (slave) - i_valid/o_ready word handshake, i_data, i_first, i_last,
//                 i_poly, i_crc seed, o_valid result pulse, o_crc, o_busy
// Option: CRC_STREAM_XOROUT_EN adds bus.i_xorout, latched at frame start and
//         XORed into the result.
module crc_stream #(
    parameter int WDATA = 5,
    parameter int WPOLY = 4
) (
    input  logic         i_clk,
    input  logic         i_rst,
    crc_stream_if.slave  bus
);
    localparam int CW   = WPOLY - 1;
    localparam int CNTW = (WDATA > 1) ? $clog2(WDATA) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    r_q, r_d;
    logic [CW-1:0]    p_q, p_d;
    logic [CW-1:0]    crc_q, crc_d;
    logic [WDATA-1:0] data_q, data_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic             last_q, last_d;
    logic             open_q, open_d;
`ifdef CRC_STREAM_XOROUT_EN
    logic [CW-1:0]    xo_q, xo_d;
`endif

    logic             accept;
    logic             fb;
    logic [CW-1:0]    r_step;
    logic             poly_msb_unused;

    // The generator's leading 1 is implicit in the shift.
    assign poly_msb_unused = bus.i_poly[WPOLY-1];

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        p_d     = p_q;
        crc_d   = crc_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        open_d  = open_q;
`ifdef CRC_STREAM_XOROUT_EN
        xo_d    = xo_q;
`endif
        accept  = bus.i_valid && (state_q != SHIFT);
        fb      = r_q[CW-1] ^ data_q[WDATA-1];
        r_step  = (r_q << 1) ^ (fb ? p_q : '0);

        case (state_q)
            SHIFT: begin
                r_d    = r_step;
                data_d = data_q << 1;
                cnt_d  = cnt_q - CNTW'(1);
                if (cnt_q == '0) begin
                    if (last_q) begin
`ifdef CRC_STREAM_XOROUT_EN
                        crc_d = r_step ^ xo_q;
`else
                        crc_d = r_step;
`endif
                        open_d  = 1'b0;
                        state_d = DONE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                // IDLE and DONE both accept; DONE otherwise lasts one cycle.
                if (accept) begin
                    data_d  = bus.i_data;
                    last_d  = bus.i_last;
                    cnt_d   = CNTW'(WDATA - 1);
                    state_d = SHIFT;
                    // i_first on an open frame abandons it silently.
                    if (bus.i_first || !open_q) begin
                        r_d    = bus.i_crc;
                        p_d    = bus.i_poly[CW-1:0];
                        open_d = 1'b1;
`ifdef CRC_STREAM_XOROUT_EN
                        xo_d   = bus.i_xorout;
`endif
                    end
                end else begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            r_q     <= '0;
            p_q     <= '0;
            crc_q   <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            last_q  <= 1'b0;
            open_q  <= 1'b0;
`ifdef CRC_STREAM_XOROUT_EN
            xo_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            p_q     <= p_d;
            crc_q   <= crc_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            open_q  <= open_d;
`ifdef CRC_STREAM_XOROUT_EN
            xo_q    <= xo_d;
`endif
        end
    end

    assign bus.o_ready = (state_q != SHIFT);
    assign bus.o_valid = (state_q == DONE);
    assign bus.o_crc   = crc_q;
    assign bus.o_busy  = open_q || (state_q == SHIFT);
endmodule
